// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the multi-cycle multiply/divide unit.
package mdu_pkg;

    localparam int ITER  = 32;
    localparam int CNT_W = $clog2(ITER);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_e;

    // Bit 0 of the op code distinguishes unsigned (1) from signed (0).
    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: compare the shifted partial remainder
// against the divisor and subtract when it fits.
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    // When the subtraction happens the result is below the divisor, so the
    // low WIDTH bits carry the exact difference.
    assign q_bit    = (rem >= {1'b0, divisor});
    assign rem_next = q_bit ? (rem[WIDTH-1:0] - divisor) : rem[WIDTH-1:0];

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle shift-add multiplier / restoring divider with HI/LO registers.
//
//  state | meaning
//  IDLE  | waiting; accepts start or MTHI/MTLO writes
//  CALC  | one multiply or divide iteration per cycle, count runs 31..0
//  FIX   | apply result signs and write hi/lo
//  DONE  | done pulse for one cycle, then back to IDLE
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e             state;
    op_e                op_q;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH-1:0]   rs_raw;
    logic               sign_a;
    logic               sign_b;

    logic               start_signed;
    logic [WIDTH-1:0]   rs_mag;
    logic [WIDTH-1:0]   rt_mag;
    logic               is_mul;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   rem_next;
    logic               q_bit;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               div_zero;

    assign start_signed = is_signed_op(op);
    assign rs_mag = (start_signed && rs_data[WIDTH-1]) ? -rs_data : rs_data;
    assign rt_mag = (start_signed && rt_data[WIDTH-1]) ? -rt_data : rt_data;
    assign is_mul = ~op_q[1];

    // acc holds {partial product, remaining multiplier} for multiply and
    // {partial remainder, remaining dividend / quotient bits} for divide.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);

    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      ({acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]}),
        .divisor  (operand),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_comb begin
        prod_fix = acc;
        quo_fix  = acc[WIDTH-1:0];
        rem_fix  = acc[2*WIDTH-1:WIDTH];
        div_zero = (operand == '0);
        if (op_q == OP_MULT && (sign_a ^ sign_b))
            prod_fix = -acc;
        if (op_q == OP_DIV && (sign_a ^ sign_b))
            quo_fix = -acc[WIDTH-1:0];
        if (op_q == OP_DIV && sign_a)
            rem_fix = -acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= OP_MULT;
            count   <= '0;
            acc     <= '0;
            operand <= '0;
            rs_raw  <= '0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q   <= op_e'(op);
                        rs_raw <= rs_data;
                        sign_a <= start_signed & rs_data[WIDTH-1];
                        sign_b <= start_signed & rt_data[WIDTH-1];
                        count  <= CNT_W'(ITER - 1);
                        busy   <= 1'b1;
                        state  <= CALC;
                        if (~op[1]) begin
                            acc     <= {{WIDTH{1'b0}}, rt_mag};
                            operand <= rs_mag;
                        end else begin
                            acc     <= {{WIDTH{1'b0}}, rs_mag};
                            operand <= rt_mag;
                        end
                    end else begin
                        if (hi_we) hi <= wr_data;
                        if (lo_we) lo <= wr_data;
                    end
                end
                CALC: begin
                    if (is_mul)
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    else
                        acc <= {rem_next, acc[WIDTH-2:0], q_bit};
                    if (count == '0)
                        state <= FIX;
                    else
                        count <= count - 1'b1;
                end
                FIX: begin
                    if (is_mul) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else if (div_zero) begin
                        hi <= rs_raw;
                        lo <= '1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed vector table plus hand sequences for start-while-busy, reset and MTHI/MTLO.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Launch an op and wait (bounded) for done; returns at the negedge where done is high.
    // Operand inputs are scrambled after the start edge.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic ok,
                         output logic [31:0] mid_hi, output logic [31:0] mid_lo);
        @(negedge clk);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(negedge clk);
        start = 1'b0; rs_data = $urandom; rt_data = $urandom;
        lat = 0; ok = 1'b0; mid_hi = hi; mid_lo = lo;
        while (lat < 100 && !ok) begin
            if (done) ok = 1'b1;
            else begin
                if (lat == 16) begin mid_hi = hi; mid_lo = lo; end
                @(negedge clk);
                lat++;
            end
        end
    endtask

    initial begin
        int          lat;
        logic        ok;
        logic [31:0] mid_hi, mid_lo, prev_hi, prev_lo, got_hi, got_lo;
        int          pulses;

        vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
        vecs[5]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[6]  = '{2'b10, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
        vecs[7]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[8]  = '{2'b11, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
        vecs[9]  = '{2'b01, 32'h12345678, 32'h00000009, 32'h00000000, 32'hA3D70A38};
        vecs[10] = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
        vecs[11] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};

        rst = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
        hi_we = 1'b0; lo_we = 1'b0; wr_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);

        for (int i = 0; i < 12; i++) begin
            prev_hi = hi; prev_lo = lo;
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, ok, mid_hi, mid_lo);
            chk($sformatf("v%0d_done_seen", i), {31'b0, ok}, 32'd1);
            chk($sformatf("v%0d_latency", i), lat, 32'd33);
            chk($sformatf("v%0d_mid_hi", i), mid_hi, prev_hi);
            chk($sformatf("v%0d_mid_lo", i), mid_lo, prev_lo);
            chk($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
            chk($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
            @(negedge clk);
            chk($sformatf("v%0d_done_after", i), {31'b0, done}, 32'd0);
            chk($sformatf("v%0d_busy_after", i), {31'b0, busy}, 32'd0);
        end

        // start pulses and operand changes while busy are ignored
        @(negedge clk);
        start = 1'b1; op = 2'b11; rs_data = 32'd100; rt_data = 32'd7;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b1; op = 2'($urandom); rs_data = $urandom; rt_data = $urandom;
        end
        @(negedge clk);
        start = 1'b0;
        pulses = 0; got_hi = '0; got_lo = '0;
        for (int k = 0; k < 60; k++) begin
            if (done) begin pulses++; got_hi = hi; got_lo = lo; end
            @(negedge clk);
        end
        chk("busy_start_pulses", pulses, 32'd1);
        chk("busy_start_lo", got_lo, 32'd14);
        chk("busy_start_hi", got_hi, 32'd2);

        // reset mid-operation
        @(negedge clk);
        start = 1'b1; op = 2'b11; rs_data = 32'd100; rt_data = 32'd7;
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
            start = 1'b1; rs_data = $urandom; rt_data = $urandom;
        end
        @(negedge clk);
        start = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        do_op(2'b01, 32'd6, 32'd7, lat, ok, mid_hi, mid_lo);
        chk("postrst_done_seen", {31'b0, ok}, 32'd1);
        chk("postrst_latency", lat, 32'd33);
        chk("postrst_lo", lo, 32'd42);
        chk("postrst_hi", hi, 32'd0);
        @(negedge clk);

        // MTHI / MTLO
        hi_we = 1'b1; wr_data = 32'hA5A5A5A5;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi_idle", hi, 32'hA5A5A5A5);
        chk("mthi_lo_untouched", lo, 32'd42);
        hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'h0BADF00D;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        chk("both_we_hi", hi, 32'h0BADF00D);
        chk("both_we_lo", lo, 32'h0BADF00D);
        hi_we = 1'b1; wr_data = 32'hA5A5A5A5;
        @(negedge clk);
        hi_we = 1'b0;

        start = 1'b1; op = 2'b01; rs_data = 32'd2; rt_data = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'h11111111;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        chk("mthi_busy_hi", hi, 32'hA5A5A5A5);
        chk("mtlo_busy_lo", lo, 32'h0BADF00D);
        lat = 0;
        while (!done && lat < 100) begin @(negedge clk); lat++; end
        chk("busy_we_done_seen", {31'b0, done}, 32'd1);
        chk("busy_we_hi", hi, 32'd0);
        chk("busy_we_lo", lo, 32'd6);
        repeat (2) @(negedge clk);

        // start wins over lo_we in the same cycle
        start = 1'b1; op = 2'b01; rs_data = 32'd3; rt_data = 32'd5;
        lo_we = 1'b1; wr_data = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0; lo_we = 1'b0;
        chk("start_lo_we_lo", lo, 32'd6);
        chk("start_lo_we_busy", {31'b0, busy}, 32'd1);
        lat = 0;
        while (!done && lat < 100) begin @(negedge clk); lat++; end
        chk("start_lo_we_done_seen", {31'b0, done}, 32'd1);
        chk("start_lo_we_result", lo, 32'd15);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
